// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges the W-stage writeback and the late mult/div
// result. Optional `define GRF_WB_TRACE_EN prints each committed register write.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_a3,
  input  logic [31:0]   pipe_wd,
  input  logic [31:0]   pipe_pc,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_a3,
  input  logic [31:0]   md_wd,
  input  logic [31:0]   md_pc,
  output logic          grf_we,
  output logic [4:0]    grf_a3,
  output logic [31:0]   grf_wd,
  output logic [31:0]   grf_pc,
  output logic [CW-1:0] pend_cnt,
  output logic          busy
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] ent_valid;
  logic [4:0]       ent_a3 [DEPTH];
  logic [31:0]      ent_wd [DEPTH];
  logic [31:0]      ent_pc [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;

  logic             pipe_req, md_xfer, md_keep, fifo_empty, do_push, do_pop;
  logic [DEPTH-1:0] kill;

  assign md_ready = reset && (cnt < CW'(DEPTH));
  assign pend_cnt = cnt;
  assign busy     = (cnt != '0);

  always_comb begin
    pipe_req   = pipe_we && (pipe_a3 != '0);
    md_xfer    = md_valid && md_ready;
    md_keep    = md_xfer && (md_a3 != '0);
    fifo_empty = (cnt == '0);
    do_pop     = !pipe_req && !fifo_empty;
    // md results only enter the FIFO when they cannot be written this cycle
    do_push    = md_keep && (pipe_req || !fifo_empty);
    kill       = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      kill[i] = pipe_req && (ent_a3[PW'(i)] == pipe_a3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_a3[PW'(i)] <= '0;
        ent_wd[PW'(i)] <= '0;
        ent_pc[PW'(i)] <= '0;
      end
    end else begin
      ent_valid <= ent_valid & ~kill;
      if (do_push) begin
        // a same-cycle pipe write to the same register supersedes this entry
        ent_valid[wr_ptr] <= !(pipe_req && (md_a3 == pipe_a3));
        ent_a3[wr_ptr]    <= md_a3;
        ent_wd[wr_ptr]    <= md_wd;
        ent_pc[wr_ptr]    <= md_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (!do_push && do_pop)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
    end else if (pipe_req) begin
      grf_we <= 1'b1;
      grf_a3 <= pipe_a3;
      grf_wd <= pipe_wd;
      grf_pc <= pipe_pc;
    end else if (!fifo_empty) begin
      grf_we <= ent_valid[rd_ptr];
      if (ent_valid[rd_ptr]) begin
        grf_a3 <= ent_a3[rd_ptr];
        grf_wd <= ent_wd[rd_ptr];
        grf_pc <= ent_pc[rd_ptr];
      end
    end else if (md_keep) begin
      grf_we <= 1'b1;
      grf_a3 <= md_a3;
      grf_wd <= md_wd;
      grf_pc <= md_pc;
    end else begin
      grf_we <= 1'b0;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we && (grf_a3 != '0))
      $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd);
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: fixed vector table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_grf_wb_arbiter;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we, md_valid, md_ready, grf_we, busy;
  logic [4:0]  pipe_a3, md_a3, grf_a3;
  logic [31:0] pipe_wd, pipe_pc, md_wd, md_pc, grf_wd, grf_pc;
  logic [2:0]  pend_cnt;

  grf_wb_arbiter #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pend_cnt(pend_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;
  logic        last_xfer;
  logic        rdy_seen;
  int          wlog[$];

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   rdy  = (mq.size() < DEPTH);
    bit   keep;
    bit   preq = pipe_we && (pipe_a3 != 0);
    last_xfer = md_valid && rdy;
    keep = last_xfer && (md_a3 != 0);
    if (preq) begin
      foreach (mq[i]) if (mq[i].a3 == pipe_a3) mq[i].v = 0;
      m_we = 1; m_a3 = pipe_a3; m_wd = pipe_wd; m_pc = pipe_pc;
      if (keep) mq.push_back('{md_a3 != pipe_a3, md_a3, md_wd, md_pc});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = e.v;
      if (e.v) begin m_a3 = e.a3; m_wd = e.wd; m_pc = e.pc; end
      if (keep) mq.push_back('{1'b1, md_a3, md_wd, md_pc});
    end else if (keep) begin
      m_we = 1; m_a3 = md_a3; m_wd = md_wd; m_pc = md_pc;
    end else begin
      m_we = 0;
    end
    if (m_we) wlog.push_back(int'(m_a3));
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    #1;
    rdy_seen = md_ready;
    chk("md_ready", md_ready, mq.size() < DEPTH);
    model_step();
    @(posedge clk); #1;
    chk("grf_we", grf_we, m_we);
    chk("grf_a3", grf_a3, m_a3);
    chk("grf_wd", grf_wd, m_wd);
    chk("grf_pc", grf_pc, m_pc);
    chk("pend_cnt", pend_cnt, mq.size());
    chk("busy", busy, mq.size() != 0);
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
    md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic pwe; logic [4:0] pa3; logic [31:0] pwd, ppc;
    logic mv;  logic [4:0] ma3; logic [31:0] mwd, mpc;
    logic rdy, we; logic [4:0] a3; logic [31:0] wd, pc; logic [2:0] cnt;
  } vec_t;
  vec_t tbl[10];

  int nx;

  initial begin
    tbl[0] = '{1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0,                    1, 1, 5, 32'h1234, 32'h3000, 0};
    tbl[1] = '{0, 0, 0, 0,                 1, 8, 32'hDEADBEEF, 32'h4000, 1, 1, 8, 32'hDEADBEEF, 32'h4000, 0};
    tbl[2] = '{0, 0, 0, 0,                 0, 0, 0, 0,                   1, 0, 8, 32'hDEADBEEF, 32'h4000, 0};
    tbl[3] = '{1, 0, 32'h5555, 32'h5000,   1, 0, 32'h6666, 32'h6000,     1, 0, 8, 32'hDEADBEEF, 32'h4000, 0};
    tbl[4] = '{1, 7, 32'h77, 32'h7000,     1, 3, 32'hA, 32'h2000,        1, 1, 7, 32'h77, 32'h7000, 1};
    tbl[5] = '{1, 3, 32'hB, 32'h7004,      0, 0, 0, 0,                   1, 1, 3, 32'hB, 32'h7004, 1};
    tbl[6] = '{0, 0, 0, 0,                 0, 0, 0, 0,                   1, 0, 3, 32'hB, 32'h7004, 0};
    tbl[7] = '{1, 4, 32'h44, 32'h7008,     1, 4, 32'h99, 32'h2004,       1, 1, 4, 32'h44, 32'h7008, 1};
    tbl[8] = '{0, 0, 0, 0,                 1, 6, 32'h66, 32'h2008,       1, 0, 4, 32'h44, 32'h7008, 1};
    tbl[9] = '{0, 0, 0, 0,                 0, 0, 0, 0,                   1, 1, 6, 32'h66, 32'h2008, 0};

    idle_inputs();
    last_xfer = 1;
    model_reset();
    reset = 0;
    #12;
    chk("rst_grf_we", grf_we, 0);
    chk("rst_grf_a3", grf_a3, 0);
    chk("rst_grf_wd", grf_wd, 0);
    chk("rst_grf_pc", grf_pc, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_md_ready", md_ready, 0);
    #1 reset = 1;
    @(posedge clk); #1;

    // table: pipe write, bypass, hold, zero register, invalidation
    for (int i = 0; i < 10; i++) begin
      pipe_we = tbl[i].pwe; pipe_a3 = tbl[i].pa3; pipe_wd = tbl[i].pwd; pipe_pc = tbl[i].ppc;
      md_valid = tbl[i].mv; md_a3 = tbl[i].ma3; md_wd = tbl[i].mwd; md_pc = tbl[i].mpc;
      cycle();
      chk($sformatf("vec%0d_ready", i), rdy_seen, tbl[i].rdy);
      chk($sformatf("vec%0d_we", i), grf_we, tbl[i].we);
      chk($sformatf("vec%0d_a3", i), grf_a3, tbl[i].a3);
      chk($sformatf("vec%0d_wd", i), grf_wd, tbl[i].wd);
      chk($sformatf("vec%0d_pc", i), grf_pc, tbl[i].pc);
      chk($sformatf("vec%0d_cnt", i), pend_cnt, tbl[i].cnt);
    end

    // back-pressure: pipe owns the port for 6 cycles, md offers 9..14
    idle_inputs();
    wlog.delete();
    nx = 0;
    for (int i = 1; i <= 6; i++) begin
      pipe_we = 1; pipe_a3 = 5'(i); pipe_wd = 32'(i * 16); pipe_pc = 32'h8000 + 32'(i * 4);
      md_valid = 1; md_a3 = 5'(9 + nx); md_wd = 32'(100 + nx); md_pc = 32'h9000 + 32'(nx * 4);
      cycle();
      if (last_xfer) nx++;
    end
    chk("bp_transfers", nx, 4);
    chk("bp_pend_cnt", pend_cnt, 4);
    chk("bp_md_ready", md_ready, 0);
    pipe_we = 0; pipe_a3 = 0;
    for (int c = 0; c < 30 && wlog.size() < 12; c++) begin
      md_valid = (nx < 6); md_a3 = 5'(9 + nx); md_wd = 32'(100 + nx); md_pc = 32'h9000 + 32'(nx * 4);
      cycle();
      if (last_xfer && md_valid) nx++;
    end
    chk("bp_drain_done", wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++)
      chk($sformatf("bp_order%0d", i), wlog[i], (i < 6) ? i + 1 : i + 3);
    idle_inputs();
    cycle();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      pipe_we = ($urandom_range(0, 2) == 0);
      pipe_a3 = 5'($urandom_range(0, 7));
      pipe_wd = $urandom; pipe_pc = $urandom;
      if (!(md_valid && !last_xfer)) begin
        md_valid = ($urandom_range(0, 2) != 0);
        md_a3 = 5'($urandom_range(0, 7));
        md_wd = $urandom; md_pc = $urandom;
      end
      cycle();
    end

    // reset mid-drain with 3 pending entries
    idle_inputs();
    for (int c = 0; c < 10 && mq.size() != 0; c++) cycle();
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1; pipe_a3 = 5'(i + 1); pipe_wd = 32'(i); pipe_pc = 32'hA000 + 32'(i * 4);
      md_valid = 1; md_a3 = 5'(20 + i); md_wd = 32'(200 + i); md_pc = 32'hB000 + 32'(i * 4);
      cycle();
    end
    idle_inputs();
    cycle();
    chk("mid_pend_cnt", pend_cnt, 3);
    #3 reset = 0;
    #1;
    chk("mid_rst_we", grf_we, 0);
    chk("mid_rst_cnt", pend_cnt, 0);
    chk("mid_rst_ready", md_ready, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("post_rst_no_write", grf_we, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
